iir_coef_scheduler: RTL and testbench

- Owns the coefficient sets for a cascade of NUM_SECT biquad IIR sections. Each set is b1, b2, b3, a2, a3, 18-bit signed.
- A host writes a shadow bank over a simple write port. A commit copies the shadow bank into the active bank at the next audio sample boundary (lrclk_posedge). On request, the commit also flushes the filter state by dropping the section valid for one cycle.
- Sits between the control/UI logic and the IIR section instances. It drives their coefficient inputs and their i_valid. It also drives an output mute window so retuning produces no clicks.

---
 rtl/iir_coef_scheduler.sv | 136 +++++++++++++
 tb/tb_iir_coef_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/iir_coef_scheduler.sv
// Coefficient bank manager for a biquad cascade: shadow bank written by the host, active bank swapped at a sample boundary.
// Latency: the swap occurs one cycle after the first lrclk strobe that follows the commit; o_coef updates on the edge leaving SWAP.
// Backpressure: o_wr_ready is low while a commit is pending; rejected writes and commits pulse o_wr_err for one cycle.
module iir_coef_scheduler #(
    parameter int NUM_SECT     = 4,
    parameter int MUTE_SAMPLES = 8,
    parameter int UNITY        = 32768
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    lrclk_posedge,
    input  logic                    i_enable,
    input  logic                    i_wr_en,
    input  logic [2:0]              i_wr_sect,
    input  logic [2:0]              i_wr_idx,
    input  logic [17:0]             i_wr_data,
    output logic                    o_wr_ready,
    input  logic                    i_commit,
    input  logic                    i_flush,
    output logic [NUM_SECT*90-1:0]  o_coef,
    output logic                    o_iir_valid,
    output logic                    o_mute,
    output logic                    o_busy,
    output logic                    o_wr_err
);

    localparam int          CW      = (MUTE_SAMPLES > 0) ? $clog2(MUTE_SAMPLES + 1) : 1;
    localparam logic [3:0]  NS      = 4'(NUM_SECT);
    localparam logic [17:0] UNITY_C = 18'(UNITY);

    typedef enum logic [1:0] {IDLE, ARMED, SWAP, MUTE} state_t;

    state_t          state_q, state_n;
    logic            flush_q, flush_n;
    logic [CW-1:0]   mute_cnt_q, mute_cnt_n;
    logic            wr_err_n;
    logic            wr_ok;
    logic            wr_accept;
    logic [17:0]     shadow_q [NUM_SECT][5];
    logic [17:0]     active_q [NUM_SECT][5];

    assign wr_ok      = ({1'b0, i_wr_sect} < NS) && (i_wr_idx <= 3'd4);
    assign wr_accept  = i_wr_en && wr_ok && ((state_q == IDLE) || (state_q == MUTE));
    assign o_wr_ready = (state_q == IDLE) || (state_q == MUTE);
    assign o_mute     = (state_q == MUTE);
    assign o_busy     = (state_q != IDLE);

    // Next-state logic: commit arming, strobe-aligned swap, mute countdown, write/commit rejection
    always_comb begin
        state_n    = state_q;
        flush_n    = flush_q;
        mute_cnt_n = mute_cnt_q;
        wr_err_n   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_wr_en && !wr_ok) wr_err_n = 1'b1;
                if (i_commit) begin
                    flush_n = i_flush;
                    state_n = ARMED;
                end
            end
            ARMED: begin
                if (i_wr_en) wr_err_n = 1'b1;
                if (lrclk_posedge) state_n = SWAP;
            end
            SWAP: begin
                if (i_wr_en) wr_err_n = 1'b1;
                if (flush_q && (MUTE_SAMPLES > 0)) begin
                    mute_cnt_n = CW'(MUTE_SAMPLES);
                    state_n    = MUTE;
                end else begin
                    state_n = IDLE;
                end
            end
            MUTE: begin
                if ((i_wr_en && !wr_ok) || i_commit) wr_err_n = 1'b1;
                if (lrclk_posedge) begin
                    mute_cnt_n = mute_cnt_q - 1'b1;
                    if (mute_cnt_q <= CW'(1)) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Control registers; the section valid is dropped for the single SWAP cycle of a flushing commit
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            flush_q     <= 1'b0;
            mute_cnt_q  <= '0;
            o_wr_err    <= 1'b0;
            o_iir_valid <= 1'b0;
        end else begin
            state_q     <= state_n;
            flush_q     <= flush_n;
            mute_cnt_q  <= mute_cnt_n;
            o_wr_err    <= wr_err_n;
            o_iir_valid <= i_enable && !((state_n == SWAP) && flush_q);
        end
    end

    // Shadow bank: host writes land here; out-of-range or blocked writes are simply not matched
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SECT; s++) begin
            for (int k = 0; k < 5; k++) begin
                if (i_rst) begin
                    shadow_q[s][k] <= (k == 0) ? UNITY_C : 18'd0;
                end else if (wr_accept && (i_wr_sect == 3'(s)) && (i_wr_idx == 3'(k))) begin
                    shadow_q[s][k] <= i_wr_data;
                end
            end
        end
    end

    // Active bank: only ever reloaded on the edge that leaves SWAP
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SECT; s++) begin
            for (int k = 0; k < 5; k++) begin
                if (i_rst) begin
                    active_q[s][k] <= (k == 0) ? UNITY_C : 18'd0;
                end else if (state_q == SWAP) begin
                    active_q[s][k] <= shadow_q[s][k];
                end
            end
        end
    end

    // Flatten the active bank: per section {a3,a2,b3,b2,b1}, b1 in the LSBs
    for (genvar gs = 0; gs < NUM_SECT; gs++) begin : g_sect
        for (genvar gk = 0; gk < 5; gk++) begin : g_coef
            assign o_coef[gs*90 + gk*18 +: 18] = active_q[gs][gk];
        end
    end

endmodule

// File: tb/tb_iir_coef_scheduler.sv
// Directed bench for iir_coef_scheduler with hand-computed expectations.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Each comparison goes through chk, which counts checks and errors.
module tb_iir_coef_scheduler;

    localparam int NUM_SECT = 4;
    localparam logic [17:0] UNITY_V = 18'd32768;
    localparam logic [17:0] NEG20K  = 18'h3B1E0;   // -20000 in 18-bit two's complement

    logic                   clk = 1'b0;
    logic                   i_rst = 1'b1;
    logic                   lrclk_posedge = 1'b0;
    logic                   i_enable = 1'b0;
    logic                   i_wr_en = 1'b0;
    logic [2:0]             i_wr_sect = 3'd0;
    logic [2:0]             i_wr_idx = 3'd0;
    logic [17:0]            i_wr_data = 18'd0;
    logic                   o_wr_ready;
    logic                   i_commit = 1'b0;
    logic                   i_flush = 1'b0;
    logic [NUM_SECT*90-1:0] o_coef;
    logic                   o_iir_valid;
    logic                   o_mute;
    logic                   o_busy;
    logic                   o_wr_err;

    int errs = 0;
    int checks = 0;

    iir_coef_scheduler #(.NUM_SECT(NUM_SECT), .MUTE_SAMPLES(8), .UNITY(32768)) dut (
        .clk(clk), .i_rst(i_rst), .lrclk_posedge(lrclk_posedge), .i_enable(i_enable),
        .i_wr_en(i_wr_en), .i_wr_sect(i_wr_sect), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
        .o_wr_ready(o_wr_ready), .i_commit(i_commit), .i_flush(i_flush), .o_coef(o_coef),
        .o_iir_valid(o_iir_valid), .o_mute(o_mute), .o_busy(o_busy), .o_wr_err(o_wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] coef(input int s, input int k);
        return o_coef[s*90 + k*18 +: 18];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic strobe();
        lrclk_posedge = 1'b1;
        cyc();
        lrclk_posedge = 1'b0;
    endtask

    task automatic wr(input logic [2:0] s, input logic [2:0] k, input logic [17:0] d);
        i_wr_en = 1'b1; i_wr_sect = s; i_wr_idx = k; i_wr_data = d;
        cyc();
        i_wr_en = 1'b0;
    endtask

    task automatic commit(input logic fl);
        i_commit = 1'b1; i_flush = fl;
        cyc();
        i_commit = 1'b0; i_flush = 1'b0;
    endtask

    initial begin
        int bad;

        // Reset state
        idle(2);
        i_rst = 1'b0;
        bad = 0;
        for (int s = 0; s < NUM_SECT; s++) begin
            if (coef(s, 0) !== UNITY_V) bad++;
            for (int k = 1; k < 5; k++) if (coef(s, k) !== 18'd0) bad++;
        end
        chk("reset_coef_bad", bad, 0);
        chk("reset_valid", o_iir_valid, 0);
        chk("reset_wr_ready", o_wr_ready, 1);
        chk("reset_busy", o_busy, 0);
        chk("reset_mute", o_mute, 0);
        i_enable = 1'b1;
        cyc();
        chk("enable_valid", o_iir_valid, 1);

        // Non-flushing commit with the strobe 50 cycles after arming
        wr(3'd1, 3'd3, NEG20K);
        chk("wr_ok_err", o_wr_err, 0);
        commit(1'b0);
        chk("armed_busy", o_busy, 1);
        chk("armed_wr_ready", o_wr_ready, 0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (coef(1, 3) !== 18'd0 || o_iir_valid !== 1'b1) bad++;
            cyc();
        end
        chk("armed_stable_bad", bad, 0);
        strobe();
        chk("swap_valid_noflush", o_iir_valid, 1);
        chk("swap_cycle_old_a2", coef(1, 3), 18'd0);
        cyc();
        chk("new_a2", coef(1, 3), NEG20K);
        chk("post_swap_busy", o_busy, 0);
        chk("post_swap_valid", o_iir_valid, 1);

        // Flushing commit with an 8-strobe mute window
        commit(1'b1);
        idle(3);
        strobe();
        chk("flush_valid_low", o_iir_valid, 0);
        cyc();
        chk("flush_valid_back", o_iir_valid, 1);
        chk("mute_on", o_mute, 1);
        chk("mute_busy", o_busy, 1);
        chk("mute_wr_ready", o_wr_ready, 1);
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            idle(2);
            if (o_mute !== 1'b1) bad++;
            if (i == 2) begin
                i_commit = 1'b1;
                cyc();
                i_commit = 1'b0;
                chk("mute_commit_err", o_wr_err, 1);
                cyc();
                chk("mute_commit_err_once", o_wr_err, 0);
            end
            strobe();
            if (i < 8 && o_mute !== 1'b1) bad++;
        end
        chk("mute_window_bad", bad, 0);
        chk("mute_off", o_mute, 0);
        chk("mute_off_busy", o_busy, 0);
        idle(3);
        chk("ignored_commit_idle", o_busy, 0);

        // Rejected writes: during ARMED and out of range
        commit(1'b0);
        wr(3'd2, 3'd0, 18'd12345);
        chk("armed_wr_err", o_wr_err, 1);
        cyc();
        chk("armed_wr_err_once", o_wr_err, 0);
        strobe();
        idle(2);
        chk("armed_wr_dropped", coef(2, 0), UNITY_V);
        wr(3'd5, 3'd0, 18'd777);
        chk("range_wr_err", o_wr_err, 1);
        cyc();
        chk("range_wr_err_once", o_wr_err, 0);
        wr(3'd1, 3'd5, 18'd999);
        chk("idx_wr_err", o_wr_err, 1);
        commit(1'b0);
        strobe();
        idle(2);
        chk("followup_s1_b1", coef(1, 0), UNITY_V);
        chk("followup_s1_a3", coef(1, 4), 18'd0);
        chk("followup_s1_a2", coef(1, 3), NEG20K);
        chk("followup_s2_b1", coef(2, 0), UNITY_V);

        // Commit coincident with a strobe waits for the next strobe
        wr(3'd0, 3'd1, 18'd1000);
        lrclk_posedge = 1'b1;
        commit(1'b0);
        lrclk_posedge = 1'b0;
        idle(3);
        chk("coinc_still_busy", o_busy, 1);
        chk("coinc_old_b2", coef(0, 1), 18'd0);
        strobe();
        cyc();
        chk("coinc_new_b2", coef(0, 1), 18'd1000);

        // Reset in the middle of a mute window (counter at 5)
        commit(1'b1);
        strobe();
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            strobe();
        end
        chk("pre_reset_mute", o_mute, 1);
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        chk("rst_mute", o_mute, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_wr_ready", o_wr_ready, 1);
        chk("rst_s1_a2", coef(1, 3), 18'd0);
        chk("rst_s0_b2", coef(0, 1), 18'd0);
        chk("rst_s0_b1", coef(0, 0), UNITY_V);
        idle(3);
        chk("rst_no_swap", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
